// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (header, N instruction bytes,
// XOR checksum), fills a 16x8 program memory and releases the CPU once the
// frame has been checked. Instruction fetch is a registered read port.
module prog_loader (
    input  logic       CLK,
    input  logic       CLB,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [7:0] fetch_addr,
    output logic [7:0] fetch_data,
    output logic       cpu_clb,
    output logic       done,
    output logic       err,
    output logic [4:0] prog_len
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSum,
        StDone,
        StRun,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  mem_q [16];
    logic [4:0]  cnt_q;
    logic [4:0]  len_q;
    logic [7:0]  xor_q;
    logic [7:0]  fetch_q;
    logic        rst_q;     // high for the first cycle after reset releases

    logic        accept;
    logic        hdr_ok;
    logic        hdr_take;

    assign accept   = in_valid & in_ready;
    assign hdr_ok   = (in_data[7:4] == 4'hA);
    // Bytes are interpreted as headers only outside an active frame.
    assign hdr_take = accept & hdr_ok &
                      ((state_q == StIdle) | (state_q == StRun) | (state_q == StErr));

    // State register.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = hdr_ok ? StLoad : StErr;
                end
            end
            StLoad: begin
                if (accept && (cnt_q == 5'd1)) begin
                    state_d = StSum;
                end
            end
            StSum: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? StDone : StErr;
                end
            end
            StDone: state_d = StRun;
            StRun, StErr: begin
                if (hdr_take) begin
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        in_ready = ~rst_q & (state_q != StDone);
        done     = (state_q == StRun);
        err      = (state_q == StErr);
        cpu_clb  = (state_q == StRun);
    end

    // Loader datapath: memory, byte counter, running checksum, length.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            rst_q <= 1'b1;
            cnt_q <= 5'd0;
            len_q <= 5'd0;
            xor_q <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            rst_q <= 1'b0;
            if (hdr_take) begin
                cnt_q <= {1'b0, in_data[3:0]} + 5'd1;
                len_q <= 5'd0;
                xor_q <= 8'h00;
                for (int i = 0; i < 16; i++) begin
                    mem_q[i] <= 8'h00;
                end
            end else if (accept && (state_q == StLoad)) begin
                mem_q[len_q[3:0]] <= in_data;
                xor_q             <= xor_q ^ in_data;
                len_q             <= len_q + 5'd1;
                cnt_q             <= cnt_q - 5'd1;
            end
        end
    end

    // Registered fetch port; only the low 16 addresses map to memory.
    always_ff @(posedge CLK) begin
        if (CLB) begin
            fetch_q <= 8'h00;
        end else if ((state_q == StRun) && (fetch_addr[7:4] == 4'h0)) begin
            fetch_q <= mem_q[fetch_addr[3:0]];
        end else begin
            fetch_q <= 8'h00;
        end
    end

    assign fetch_data = fetch_q;
    assign prog_len   = len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal load, bad checksum, bad header,
// reset mid-frame and reload while running, with optional in_valid gaps.
module tb_prog_loader;

    logic       CLK = 1'b0;
    logic       CLB;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       cpu_clb;
    logic       done;
    logic       err;
    logic [4:0] prog_len;

    int n_checks = 0;
    int n_fail   = 0;
    int gap      = 0;

    prog_loader dut (
        .CLK        (CLK),
        .CLB        (CLB),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_clb    (cpu_clb),
        .done       (done),
        .err        (err),
        .prog_len   (prog_len)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All stimulus is applied 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offer one byte, waiting (bounded) for in_ready.
    task automatic send(input logic [7:0] b);
        int n = 0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_reset();
        CLB = 1'b1;
        tick();
        CLB = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] exp);
        fetch_addr = a;
        tick();
        check(tag, {24'b0, fetch_data}, {24'b0, exp});
    endtask

    initial begin
        CLB        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        fetch_addr = 8'h00;
        tick();
        do_reset();

        // Reset state, first cycle after release.
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_cpu_clb", {31'b0, cpu_clb}, 32'd0);
        check("rst_prog_len", {27'b0, prog_len}, 32'd0);
        check("rst_fetch", {24'b0, fetch_data}, 32'd0);
        tick();
        check("rst_ready_after", {31'b0, in_ready}, 32'd1);

        // Nominal load: 11^22^34 = 07.
        send(8'hA2); send(8'h11); send(8'h22); send(8'h34); send(8'h07);
        check("done_st_ready", {31'b0, in_ready}, 32'd0);
        check("done_st_done", {31'b0, done}, 32'd0);
        check("done_st_cpu_clb", {31'b0, cpu_clb}, 32'd0);
        tick();
        check("run_done", {31'b0, done}, 32'd1);
        check("run_cpu_clb", {31'b0, cpu_clb}, 32'd1);
        check("run_prog_len", {27'b0, prog_len}, 32'd3);
        check("run_ready", {31'b0, in_ready}, 32'd1);
        fetch("nom_f01", 8'h01, 8'h22);
        fetch("nom_f05", 8'h05, 8'h00);
        fetch("nom_f12", 8'h12, 8'h00);
        fetch("nom_f00", 8'h00, 8'h11);
        fetch("nom_f02", 8'h02, 8'h34);
        // Non-header byte in RUN is ignored.
        send(8'h55);
        check("run_ign_done", {31'b0, done}, 32'd1);
        fetch("run_ign_f02", 8'h02, 8'h34);

        // Bad checksum.
        send(8'hA2); send(8'h11); send(8'h22); send(8'h34); send(8'h08);
        check("bad_sum_err", {31'b0, err}, 32'd1);
        check("bad_sum_done", {31'b0, done}, 32'd0);
        check("bad_sum_cpu_clb", {31'b0, cpu_clb}, 32'd0);
        fetch("bad_sum_fetch", 8'h01, 8'h00);
        send(8'hA0); send(8'h5C); send(8'h5C);
        tick();
        check("recov_done", {31'b0, done}, 32'd1);
        check("recov_err", {31'b0, err}, 32'd0);
        check("recov_len", {27'b0, prog_len}, 32'd1);
        fetch("recov_f00", 8'h00, 8'h5C);

        // Bad header after reset.
        do_reset();
        send(8'h52);
        check("bad_hdr_err", {31'b0, err}, 32'd1);
        send(8'h11); send(8'h00); send(8'h5C);
        check("bad_hdr_ign_err", {31'b0, err}, 32'd1);
        check("bad_hdr_ign_done", {31'b0, done}, 32'd0);
        check("bad_hdr_ign_ready", {31'b0, in_ready}, 32'd1);

        // Reset mid-load, with a stream byte offered during reset.
        send(8'hA3); send(8'h10); send(8'h20);
        check("mid_len", {27'b0, prog_len}, 32'd2);
        CLB      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h30;
        tick();
        CLB      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_len", {27'b0, prog_len}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        send(8'hA0); send(8'h44); send(8'h44);
        tick();
        check("mid_new_done", {31'b0, done}, 32'd1);
        check("mid_new_len", {27'b0, prog_len}, 32'd1);
        fetch("mid_f00", 8'h00, 8'h44);
        for (int a = 1; a < 16; a++) begin
            fetch("mid_clr", a[7:0], 8'h00);
        end

        // Reload while running, with 0..3 idle cycles between bytes.
        for (int g = 0; g < 4; g++) begin
            gap = g;
            send(8'hA1);
            check("rl_cpu_clb", {31'b0, cpu_clb}, 32'd0);
            check("rl_done", {31'b0, done}, 32'd0);
            check("rl_len0", {27'b0, prog_len}, 32'd0);
            send(8'h9A); send(8'hBC); send(8'h26);
            tick();
            check("rl_run_done", {31'b0, done}, 32'd1);
            check("rl_run_len", {27'b0, prog_len}, 32'd2);
            fetch("rl_f00", 8'h00, 8'h9A);
            fetch("rl_f01", 8'h01, 8'hBC);
            fetch("rl_f02", 8'h02, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have ports, one per line:
- CLK  in  1  clock; all state updates on rising edge.
- CLB  in  1  reset; synchronous, active-high.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid & in_ready at a CLK edge.
- fetch_addr  in  8  CPU program-counter address.
- fetch_data  out  8  instruction word: opcode [7:4], dc [3:2], reg [1:0].
- cpu_clb  out  1  active-low clear to the CPU (0 holds CPU in reset).
- done  out  1  program loaded and verified.
- err  out  1  load failed.
- prog_len  out  5  number of loaded instructions, 0..16.
REQ-002 SHALL use one clock, CLK; reset is synchronous and active-high.

Function
REQ-003 SHALL hold a 16x8 program memory, written only by the loader.
REQ-004 SHALL accept this frame on the byte stream: header, then N instruction bytes, then a checksum byte.
- Header: in_data[7:4] = 0xA and in_data[3:0] = N-1, so N = 1..16.
REQ-005 SHALL implement states IDLE, LOAD, SUM, DONE, RUN and ERR.
REQ-006 IDLE: in_ready=1.
- Valid header accepted -> LOAD.
- Header with upper nibble not 0xA -> ERR.
REQ-007 On header acceptance in any state, SHALL do all of the following:
- Clear all 16 memory entries to 0x00.
- Load the byte counter with N.
- Clear the running XOR to 0x00.
- Set prog_len to 0, done to 0, err to 0.
- Drive cpu_clb to 0 from the next cycle.
REQ-008 LOAD: each accepted byte SHALL be written to memory[k], where k = 0..N-1 in arrival order.
- Each accepted byte SHALL be XORed into the running checksum.
- prog_len SHALL increment by 1 per byte.
- After byte N is accepted -> SUM.
REQ-009 Cycles with in_valid=0 SHALL leave all state unchanged; there is no timeout.
REQ-010 SUM: on the accepted byte, if it equals the running XOR -> DONE, otherwise -> ERR.
REQ-011 DONE SHALL last exactly 1 cycle with in_ready=0, then -> RUN.
REQ-012 RUN: done=1, cpu_clb=1, in_ready=1.
- An accepted valid header restarts a load (REQ-007).
- Any other accepted byte SHALL be ignored.
REQ-013 ERR: err=1, cpu_clb=0, in_ready=1.
- Only a valid header leaves ERR, to LOAD.
- Other bytes SHALL be ignored.
REQ-014 fetch_data SHALL be registered with 1-cycle latency.
- In RUN: memory[fetch_addr[3:0]] if fetch_addr[7:4]=0, else 0x00.
- In every other state: 0x00.
REQ-015 In states other than DONE, in_ready SHALL be 1.
- Exception: in_ready SHALL be 0 in the first cycle after CLB deasserts.

Reset
REQ-016 CLB=1 SHALL set, at the next CLK edge:
- state=IDLE, memory all 0x00, in_ready=0, fetch_data=0x00.
- cpu_clb=0, done=0, err=0, prog_len=0, counter=0, XOR=0.
REQ-017 CLB mid-frame SHALL discard the partial load completely.
- The next frame after reset SHALL start with a header.
REQ-018 CLB SHALL take priority over any simultaneous stream byte.

Verification
REQ-019 Nominal load:
- Stimulus: reset, then bytes A2, 11, 22, 34, 07.
- Required: DONE for 1 cycle (in_ready=0), then done=1, cpu_clb=1, prog_len=3.
- Required: fetch_addr=01 -> fetch_data=22 one cycle later; fetch_addr=05 -> 00; fetch_addr=12 -> 00.
REQ-020 Bad checksum:
- Stimulus: A2, 11, 22, 34, 08.
- Required: err=1, done=0, cpu_clb=0, fetch_data=00.
- Required: a following A0, 5C, 5C -> done=1, memory[0]=5C.
REQ-021 Bad header:
- Stimulus: 52.
- Required: ERR, err=1, and following data bytes ignored.
REQ-022 Reset mid-load:
- Stimulus: A3, 10, 20, then CLB=1 for 1 cycle.
- Required: prog_len=0 and memory all 00.
- Required: a new frame A0, 44, 44 -> done=1, prog_len=1.
REQ-023 Reload while running:
- Stimulus: in RUN, send A1.
- Required: cpu_clb=0 and done=0 the next cycle.
- Required: 9A, BC, 26 -> done=1, fetch_addr=00 -> 9A, fetch_addr=02 -> 00.
- Required: in_valid gaps of 0-3 cycles inserted between bytes give identical results.
